// File: rtl/pll2_pkg.sv
// pll2 shared constants: default divide ratios, lock interval and legal limits.
// Optional feature macro used by the top: PLL2_GATE_UNTIL_LOCK_EN.
package pll2_pkg;

  localparam int PLL2_DEF_DIV0 = 2;
  localparam int PLL2_DEF_DIV1 = 4;
  localparam int PLL2_DEF_LOCK = 64;

  localparam int PLL2_DIV_MIN  = 2;
  localparam int PLL2_DIV_MAX  = 1024;
  localparam int PLL2_LOCK_MIN = 1;
  localparam int PLL2_LOCK_MAX = 65535;

  function automatic bit pll2_div_ok(input int d);
    return (d >= PLL2_DIV_MIN) && (d <= PLL2_DIV_MAX);
  endfunction

  function automatic bit pll2_lock_ok(input int n);
    return (n >= PLL2_LOCK_MIN) && (n <= PLL2_LOCK_MAX);
  endfunction

endpackage

// File: rtl/pll2_odiv.sv
// pll2 output divider: registered clock high for DIV/2 of every DIV input cycles.
// Held at zero (counter cleared) whenever en is low.
module pll2_odiv
  import pll2_pkg::*;
#(
  parameter int DIV = PLL2_DEF_DIV0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic clkout
);

  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  localparam logic [W-1:0] HALF = W'(DIV / 2);

  if (!pll2_div_ok(DIV)) begin : g_bad_div
    $fatal(1, "pll2_odiv: DIV=%0d outside legal range", DIV);
  end

  logic [W-1:0] cnt_q, cnt_d;
  logic         clk_q, clk_d;

  always_comb begin
    cnt_d = '0;
    clk_d = 1'b0;
    if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
      clk_d = (cnt_q < HALF);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

  assign clkout = clk_q;

endmodule

// File: rtl/pll2.sv
// pll2: two integer clock dividers plus a sticky lock flag after LOCK_CYCLES edges.
// Define PLL2_GATE_UNTIL_LOCK_EN to hold both outputs low until lock.
module pll2
  import pll2_pkg::*;
#(
  parameter int CLKOUT0_DIV = PLL2_DEF_DIV0,
  parameter int CLKOUT1_DIV = PLL2_DEF_DIV1,
  parameter int LOCK_CYCLES = PLL2_DEF_LOCK
) (
  input  logic clkin1,
  input  logic pll_rst,
  output logic clkout0,
  output logic clkout1,
  output logic pll_lock
);

  if (!pll2_div_ok(CLKOUT0_DIV)) begin : g_bad_div0
    $fatal(1, "pll2: CLKOUT0_DIV=%0d illegal", CLKOUT0_DIV);
  end
  if (!pll2_div_ok(CLKOUT1_DIV)) begin : g_bad_div1
    $fatal(1, "pll2: CLKOUT1_DIV=%0d illegal", CLKOUT1_DIV);
  end
  if (!pll2_lock_ok(LOCK_CYCLES)) begin : g_bad_lock
    $fatal(1, "pll2: LOCK_CYCLES=%0d illegal", LOCK_CYCLES);
  end

  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_V = LW'(LOCK_CYCLES);

  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          lock_q, lock_d;
  logic          div_en;

  // Counter parks at LOCK_V, so the flag can only rise once per release.
  always_comb begin
    lock_cnt_d = (lock_cnt_q == LOCK_V) ? lock_cnt_q
                                        : lock_cnt_q + LW'(1);
    lock_d     = lock_q | (lock_cnt_d == LOCK_V);
  end

  always_ff @(posedge clkin1) begin
    if (pll_rst) begin
      lock_cnt_q <= '0;
      lock_q     <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      lock_q     <= lock_d;
    end
  end

`ifdef PLL2_GATE_UNTIL_LOCK_EN
  // Dividers start on the same edge that raises the lock flag.
  assign div_en = lock_d;
`else
  assign div_en = 1'b1;
`endif

  pll2_odiv #(.DIV(CLKOUT0_DIV)) u_odiv0 (
    .clk    (clkin1),
    .rst    (pll_rst),
    .en     (div_en),
    .clkout (clkout0)
  );

  pll2_odiv #(.DIV(CLKOUT1_DIV)) u_odiv1 (
    .clk    (clkin1),
    .rst    (pll_rst),
    .en     (div_en),
    .clkout (clkout1)
  );

  assign pll_lock = lock_q;

endmodule

// File: tb/tb_pll2.sv
// Directed bench for pll2: default instance plus an odd-ratio, short-lock instance.
// Outputs are sampled 1 ns after each rising clkin1 edge.
`timescale 1ns/1ps
module tb_pll2;

  logic clkin1 = 1'b0;
  logic pll_rst = 1'b1;
  logic c0, c1, lk;
  logic d0, d1, dl;

  int n_chk = 0;
  int n_err = 0;
  int edge_k = 0;
  int lk_rises = 0;

  always #10 clkin1 = ~clkin1;

  pll2 u_dut (
    .clkin1   (clkin1),
    .pll_rst  (pll_rst),
    .clkout0  (c0),
    .clkout1  (c1),
    .pll_lock (lk)
  );

  pll2 #(
    .CLKOUT0_DIV (3),
    .CLKOUT1_DIV (5),
    .LOCK_CYCLES (5)
  ) u_dut3 (
    .clkin1   (clkin1),
    .pll_rst  (pll_rst),
    .clkout0  (d0),
    .clkout1  (d1),
    .pll_lock (dl)
  );

  always @(posedge lk) lk_rises++;

  task automatic check(input string tag, input logic got,
                       input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s edge %0d: got %b expected %b",
               tag, edge_k, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkin1);
    #1;
  endtask

  // Edge k after release; counters were k-1 going into that edge.
  task automatic run_edges(input int n);
    for (int k = 1; k <= n; k++) begin
      tick();
      edge_k = k;
      check("c0", c0, ((k - 1) % 2) < 1);
      check("c1", c1, ((k - 1) % 4) < 2);
      check("lock", lk, k >= 64);
      check("d0", d0, ((k - 1) % 3) < 1);
      check("d1", d1, ((k - 1) % 5) < 2);
      check("dlock", dl, k >= 5);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_c0"}, c0, 1'b0);
    check({tag, "_c1"}, c1, 1'b0);
    check({tag, "_lk"}, lk, 1'b0);
    check({tag, "_d0"}, d0, 1'b0);
    check({tag, "_d1"}, d1, 1'b0);
    check({tag, "_dl"}, dl, 1'b0);
  endtask

  initial begin
    tick();
    edge_k = -1;
    check_zero("rst1");
    tick();
    edge_k = 0;
    check_zero("rst2");
    pll_rst = 1'b0;

    // first edges by hand: c0 1010, c1 1100, d0 100, d1 11000
    tick(); edge_k = 1;
    check("h1_c0", c0, 1'b1); check("h1_c1", c1, 1'b1);
    check("h1_d0", d0, 1'b1); check("h1_d1", d1, 1'b1);
    tick(); edge_k = 2;
    check("h2_c0", c0, 1'b0); check("h2_c1", c1, 1'b1);
    check("h2_d0", d0, 1'b0); check("h2_d1", d1, 1'b1);
    tick(); edge_k = 3;
    check("h3_c0", c0, 1'b1); check("h3_c1", c1, 1'b0);
    check("h3_d0", d0, 1'b0); check("h3_d1", d1, 1'b0);
    check("h3_dl", dl, 1'b0);

    pll_rst = 1'b1;
    tick();
    edge_k = 0;
    check_zero("rst3");
    pll_rst = 1'b0;
    run_edges(520);
    check("rises1", lk_rises == 1, 1'b1);

    // one-edge reset pulse mid-operation
    pll_rst = 1'b1;
    tick();
    edge_k = 0;
    check_zero("pulse");
    pll_rst = 1'b0;
    run_edges(100);
    check("rises2", lk_rises == 2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
